// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle: memory request/response channel plus the
// instruction hand-off to decode. The fetch unit is the master of both.
interface instr_fetch_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_misalign;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-entry instruction fetch stage. Latches the PC, issues one memory
// request at a time, holds the returned word for decode and pulses pc_adv
// when decode consumes it. Flush abandons whatever is in flight.
module instr_fetch #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  input  logic              flush,
  output logic              pc_adv,
  instr_fetch_if.master     bus
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StHold} state_e;

  state_e          state_q, state_d;
  logic            latched_q, latched_d;  // addr_q holds the pc for this REQ visit
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misalign_q, misalign_d;
  logic            addr_ok;
  logic            req_fire;

  assign addr_ok            = (addr_q[1:0] == 2'b00);
  assign bus.imem_req_valid = (state_q == StReq) && latched_q && addr_ok;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.imem_addr      = addr_q;
  assign bus.inst_valid     = (state_q == StHold);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_misalign  = misalign_q;
  // Flush beats a same-cycle consume, so the PC stage only advances on a clean handshake.
  assign pc_adv             = (state_q == StHold) && bus.inst_ready && !flush;

  // Next-state and datapath selection for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    latched_d  = latched_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = misalign_q;
    unique case (state_q)
      StIdle: begin
        state_d   = StReq;
        latched_d = 1'b0;
      end
      StReq: begin
        if (flush) begin
          // Relatch next cycle; if memory already took the request, drain its response.
          latched_d = 1'b0;
          if (req_fire) begin
            state_d = StDrain;
          end
        end else if (!latched_q) begin
          addr_d    = pc;
          latched_d = 1'b1;
        end else if (!addr_ok) begin
          state_d    = StHold;
          inst_d     = '0;
          inst_pc_d  = addr_q;
          misalign_d = 1'b1;
        end else if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush && bus.imem_rsp_valid) begin
          state_d   = StReq;
          latched_d = 1'b0;
        end else if (flush) begin
          state_d = StDrain;
        end else if (bus.imem_rsp_valid) begin
          state_d    = StHold;
          inst_d     = bus.imem_rsp_data;
          inst_pc_d  = addr_q;
          misalign_d = 1'b0;
        end
      end
      StDrain: begin
        if (bus.imem_rsp_valid) begin
          state_d   = StReq;
          latched_d = 1'b0;
        end
      end
      StHold: begin
        if (flush || bus.inst_ready) begin
          state_d   = StReq;
          latched_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        latched_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      latched_q  <= 1'b0;
      addr_q     <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      latched_q  <= latched_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
